uart_rx_frame_ctrl: RTL
=======================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame controller of the UART receiver; wraps the data sampler in the RX path.
//  Detects the start bit and runs the edge and bit counters.
//  Drives dat_samp_en/edge_cnt into data_sampling and consumes its sampled_bit.
//  Deserializes the data LSB-first, checks parity and stop, and emits P_DATA with a data_valid pulse.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame (bit counter width = $clog2(DATA_WIDTH+1))
// PORTS
//  CLK          in   1   system clock (oversampling clock); only clock
//  RST          in   1   synchronous, active-high reset
//  RX_IN        in   1   serial line, idle high
//  prescale     in   6   oversampling ratio: 4/8/16/32; any other value behaves as 8
//  PAR_EN       in   1   1 = frame carries a parity bit
//  PAR_TYP      in   1   0 = even, 1 = odd parity
//  sampled_bit  in   1   majority-voted bit from data_sampling
//  dat_samp_en  out  1   sampler enable; 1 in every state except IDLE
//  edge_cnt     out  5   oversampling edge index within the current bit, 0..P-1
//  P_DATA       out  DATA_WIDTH  last good frame; holds until the next good frame
//  data_valid   out  1   1-cycle pulse when P_DATA updates
//  par_err      out  1   1-cycle pulse: parity mismatch (frame dropped)
//  stp_err      out  1   1-cycle pulse: stop bit sampled 0 (frame dropped)
//  strt_glitch  out  1   1-cycle pulse: start bit sampled 1 (aborted)
// BEHAVIOUR
//  Reset: state=IDLE. edge_cnt, bit_cnt, shift reg and P_DATA are 0. All pulses are 0. dat_samp_en is 0.
//  Reset mid-frame aborts at the next edge, with no pulses.
//  Config latch: prescale (normalised to P), PAR_EN and PAR_TYP are latched on IDLE->START.
//   Changes to these inputs mid-frame are ignored.
//  Edge counter: edge_cnt=0 in IDLE; increments each cycle in the other states.
//   It wraps to 0 at P-1; bit_end := (edge_cnt==P-1).
//   sampled_bit is stable at bit_end for every P, because the sampler's last capture is at edge P/2.
//  FSM (transitions taken only at bit_end unless stated):
//   IDLE   : RX_IN==0 (same cycle) -> START, edge_cnt=0 in the first START cycle.
//   START  : sampled_bit==0 -> DATA, bit_cnt=0.
//            sampled_bit==1 -> pulse strt_glitch, -> IDLE.
//   DATA   : shreg <= {sampled_bit, shreg[DW-1:1]}; bit_cnt++.
//            After the DATA_WIDTH-th bit -> PARITY if PAR_EN, else -> STOP.
//   PARITY : exp = ^shreg ^ PAR_TYP; perr_q <= (sampled_bit != exp). -> STOP.
//   STOP   : serr = ~sampled_bit.
//            If serr: pulse stp_err. If perr_q: pulse par_err. Both may pulse together.
//            If neither: P_DATA <= shreg and pulse data_valid.
//            Next: RX_IN==0 -> START (back-to-back frames, no idle cycle); else -> IDLE.
//  Outputs are registered; the pulses assert the cycle after bit_end.
//  perr_q clears on START entry.
//  Frame length in cycles = P*(2+DW+PAR_EN) + 1 (the IDLE detection cycle).
// CONFIGURATION
//  UART_RX_FRAME_ERR_CNT_EN defined: adds output port err_cnt [7:0].
//   err_cnt increments once per frame with par_err|stp_err and saturates at 255.
//   A strt_glitch is not counted. Reset value is 0.
//  UART_RX_FRAME_ERR_CNT_EN undefined: the port and the counter logic are absent.
//   All other behaviour is identical.
// STRUCTURE
//  Package uart_rx_pkg holds:
//   - state encodings (IDLE/START/DATA/PARITY/STOP)
//   - the legal prescale constants 4/8/16/32 and the normalisation function
//   - the default DATA_WIDTH
//  Sub-module uart_rx_edge_bit_counter holds edge_cnt and bit_cnt.
//   Inputs: enable, P, count_bit. Outputs: bit_end, bits_done.
//  The FSM, shift register and checks live in this module.
// TESTING
//  Bench instantiates data_sampling in the loop; line driven at P cycles per bit.
//  1. P=8, PAR_EN=0, frame 0xA5 -> P_DATA=0xA5, data_valid for 1 cycle at cycle 81, no errors.
//  2. P=16, PAR_EN=1, PAR_TYP=0, 0x3C, parity bit 1 -> par_err pulse; P_DATA unchanged; data_valid=0.
//  3. P=4, stop bit 0 -> stp_err pulse; next frame 0x5A -> data_valid, P_DATA=0x5A.
//  4. RX_IN low for 2 cycles, then high, P=16 -> strt_glitch pulse; returns to IDLE; dat_samp_en=0.
//  5. P=32, back-to-back frames 0x01 and 0xFF with no idle gap -> two data_valid pulses.
//     Change prescale mid-frame -> no effect.
//  6. RST asserted mid-DATA -> all outputs return to reset values the next cycle.
//     With the macro defined: 300 bad frames -> err_cnt==255.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: FSM states,
// legal oversampling ratios and prescale normalisation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_4  = 6'd4;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Unsupported ratios fall back to 8x oversampling.
    function automatic logic [5:0] norm_prescale(input logic [5:0] raw);
        case (raw)
            PRESCALE_4, PRESCALE_8, PRESCALE_16, PRESCALE_32: return raw;
            default: return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and received-data-bit counter for the UART RX
// frame controller.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic [5:0] P,
    input  logic       count_bit,
    output logic [4:0] edge_cnt,
    output logic       bit_end,
    output logic       bits_done
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    logic [4:0]           edge_cnt_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [4:0]           edge_last;

    assign edge_last = 5'(P - 6'd1);
    assign edge_cnt  = edge_cnt_reg;
    assign bit_end   = enable && (edge_cnt_reg == edge_last);
    // Asserted while the final data bit of the frame is being received.
    assign bits_done = (bit_cnt_reg == BIT_CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            if (!enable || bit_end) begin
                edge_cnt_reg <= '0;
            end else begin
                edge_cnt_reg <= edge_cnt_reg + 5'd1;
            end

            if (!enable) begin
                bit_cnt_reg <= '0;
            end else if (count_bit) begin
                bit_cnt_reg <= bits_done ? '0 : bit_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialisation,
// parity/stop checking. Define UART_RX_FRAME_ERR_CNT_EN to add the err_cnt port.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
`ifdef UART_RX_FRAME_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    rx_state_e state_reg, state_next;

    logic [5:0]            p_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
    logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
    logic                  perr_reg, perr_next;
    logic                  data_valid_reg, data_valid_next;
    logic                  par_err_reg, par_err_next;
    logic                  stp_err_reg, stp_err_next;
    logic                  strt_glitch_reg, strt_glitch_next;
    logic                  latch_cfg;

    logic cnt_enable;
    logic count_bit;
    logic bit_end;
    logic bits_done;

    assign cnt_enable = (state_reg != ST_IDLE);
    assign count_bit  = (state_reg == ST_DATA) && bit_end;

    uart_rx_edge_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_counter (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (cnt_enable),
        .P         (p_reg),
        .count_bit (count_bit),
        .edge_cnt  (edge_cnt),
        .bit_end   (bit_end),
        .bits_done (bits_done)
    );

    always_comb begin
        state_next       = state_reg;
        shreg_next       = shreg_reg;
        p_data_next      = p_data_reg;
        perr_next        = perr_reg;
        data_valid_next  = 1'b0;
        par_err_next     = 1'b0;
        stp_err_next     = 1'b0;
        strt_glitch_next = 1'b0;
        latch_cfg        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_next = ST_START;
                    latch_cfg  = 1'b1;
                    perr_next  = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    if (sampled_bit) begin
                        strt_glitch_next = 1'b1;
                        state_next       = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_next = {sampled_bit, shreg_reg[DATA_WIDTH-1:1]};
                    if (bits_done) begin
                        state_next = par_en_reg ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    perr_next  = (sampled_bit != (^shreg_reg ^ par_typ_reg));
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    stp_err_next = ~sampled_bit;
                    par_err_next = perr_reg;
                    if (sampled_bit && !perr_reg) begin
                        p_data_next     = shreg_reg;
                        data_valid_next = 1'b1;
                    end
                    // A low line here is already the next frame's start bit.
                    if (!RX_IN) begin
                        state_next = ST_START;
                        latch_cfg  = 1'b1;
                        perr_next  = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            p_reg           <= PRESCALE_8;
            par_en_reg      <= 1'b0;
            par_typ_reg     <= 1'b0;
            shreg_reg       <= '0;
            p_data_reg      <= '0;
            perr_reg        <= 1'b0;
            data_valid_reg  <= 1'b0;
            par_err_reg     <= 1'b0;
            stp_err_reg     <= 1'b0;
            strt_glitch_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shreg_reg       <= shreg_next;
            p_data_reg      <= p_data_next;
            perr_reg        <= perr_next;
            data_valid_reg  <= data_valid_next;
            par_err_reg     <= par_err_next;
            stp_err_reg     <= stp_err_next;
            strt_glitch_reg <= strt_glitch_next;
            if (latch_cfg) begin
                p_reg       <= norm_prescale(prescale);
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
            end
        end
    end

    assign dat_samp_en = (state_reg != ST_IDLE);
    assign P_DATA      = p_data_reg;
    assign data_valid  = data_valid_reg;
    assign par_err     = par_err_reg;
    assign stp_err     = stp_err_reg;
    assign strt_glitch = strt_glitch_reg;

`ifdef UART_RX_FRAME_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // One count per dropped frame, even when both errors fire together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_reg <= '0;
        end else if ((par_err_next || stp_err_next) && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule
